mem_stage: RTL

Memory-access stage between EX and WB of the multi-cycle CPU. It takes one EX result per transaction and performs LW/SW against a private word-addressed data memory with configurable wait states. It forwards the register-write tuple to WB, substituting load data for LW and suppressing the register write for SW. A valid/ready handshake on both sides replaces the fixed `StageEX`→`StageWB` step, so memory latency can stall the core.

---
 rtl/mem_stage_if.sv | 33 +++
 rtl/mem_stage.sv | 139 +++++++++++++
 2 files changed

// File: rtl/mem_stage_if.sv
// EX->MEM->WB handshake bundle for mem_stage: valid/ready on both sides plus the register-write tuple.
// master = surrounding core (drives EX side, consumes WB side); slave = the stage.
interface mem_stage_if;
  logic        ex_valid;
  logic        ex_ready;
  logic [5:0]  ex_opcode;
  logic [31:0] ex_aluout;
  logic [31:0] ex_store_data;
  logic [4:0]  ex_reg_write_addr;
  logic        ex_reg_write_flag;
  logic        ex_halt;

  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_reg_write_addr;
  logic [31:0] wb_reg_write_data;
  logic        wb_reg_write_flag;
  logic        wb_halt;

  modport master (
    output ex_valid, ex_opcode, ex_aluout, ex_store_data,
           ex_reg_write_addr, ex_reg_write_flag, ex_halt, wb_ready,
    input  ex_ready, wb_valid, wb_reg_write_addr, wb_reg_write_data,
           wb_reg_write_flag, wb_halt
  );

  modport slave (
    input  ex_valid, ex_opcode, ex_aluout, ex_store_data,
           ex_reg_write_addr, ex_reg_write_flag, ex_halt, wb_ready,
    output ex_ready, wb_valid, wb_reg_write_addr, wb_reg_write_data,
           wb_reg_write_flag, wb_halt
  );
endinterface

// File: rtl/mem_stage.sv
// Memory-access stage: LW/SW against a private word-addressed RAM with WAIT_CYCLES wait states.
// Optional feature macro: MEM_STAGE_MISALIGN_CHECK_EN (misaligned LW/SW rejected, sticky misalign_err).
module mem_stage #(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic      clk,
  input  logic      rst,
  mem_stage_if.slave bus,
  output logic      misalign_err
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  localparam logic [5:0] OP_LW = 6'd16;
  localparam logic [5:0] OP_SW = 6'd24;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  logic [1:0]  state;
  logic [3:0]  wcnt;

  logic [5:0]  op_q;
  logic [31:0] alu_q;
  logic [31:0] sd_q;
  logic [4:0]  rd_q;
  logic        flag_q;
  logic        halt_q;

  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        wb_flag;
  logic        wb_halt_r;

  logic [31:0] mem [DEPTH];

  logic [ADDR_W-1:0] idx;
  logic              is_mem_q;
  logic              misaligned_q;
  logic              acc_mem;
  logic              mem_we;

  assign idx = alu_q[ADDR_W+1:2];

  always_comb begin
    is_mem_q     = (op_q == OP_LW) || (op_q == OP_SW);
    misaligned_q = 1'b0;
    acc_mem      = (bus.ex_opcode == OP_LW) || (bus.ex_opcode == OP_SW);
`ifdef MEM_STAGE_MISALIGN_CHECK_EN
    misaligned_q = is_mem_q && (alu_q[1:0] != 2'b00);
    acc_mem      = acc_mem && (bus.ex_aluout[1:0] == 2'b00);
`endif
    mem_we = (state == S_ACCESS) && (wcnt == '0) && (op_q == OP_SW) && !misaligned_q;
  end

  // Reset forces IDLE asynchronously, so an aborted SW can never reach mem_we.
  always_ff @(posedge clk) begin
    if (mem_we) mem[idx] <= sd_q;
  end

  // Every accepted op passes through ACCESS; non-memory and rejected ops enter it
  // with wcnt=0, so their result registers from the captured inputs one edge later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      wcnt      <= '0;
      op_q      <= '0;
      alu_q     <= '0;
      sd_q      <= '0;
      rd_q      <= '0;
      flag_q    <= 1'b0;
      halt_q    <= 1'b0;
      wb_addr   <= '0;
      wb_data   <= '0;
      wb_flag   <= 1'b0;
      wb_halt_r <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.ex_valid) begin
            op_q   <= bus.ex_opcode;
            alu_q  <= bus.ex_aluout;
            sd_q   <= bus.ex_store_data;
            rd_q   <= bus.ex_reg_write_addr;
            flag_q <= bus.ex_reg_write_flag;
            halt_q <= bus.ex_halt;
            wcnt   <= acc_mem ? WAIT_INIT : '0;
            state  <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (wcnt != '0) begin
            wcnt <= wcnt - 4'd1;
          end else begin
            state     <= S_RESP;
            wb_addr   <= rd_q;
            wb_halt_r <= halt_q;
            if (!is_mem_q) begin
              wb_data <= alu_q;
              wb_flag <= flag_q;
            end else if (misaligned_q || (op_q == OP_SW)) begin
              wb_data <= alu_q;
              wb_flag <= 1'b0;
            end else begin
              wb_data <= mem[idx];
              wb_flag <= flag_q;
            end
          end
        end
        S_RESP: begin
          if (bus.wb_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef MEM_STAGE_MISALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      misalign_err <= 1'b0;
    else if ((state == S_ACCESS) && (wcnt == '0) && misaligned_q)
      misalign_err <= 1'b1;
  end
`else
  assign misalign_err = 1'b0;
`endif

  assign bus.ex_ready          = (state == S_IDLE);
  assign bus.wb_valid          = (state == S_RESP);
  assign bus.wb_reg_write_addr = wb_addr;
  assign bus.wb_reg_write_data = wb_data;
  assign bus.wb_reg_write_flag = wb_flag;
  assign bus.wb_halt           = wb_halt_r;

endmodule
